// File: rtl/input_spike_scheduler.sv
// Input-layer frame controller: loads a thresholded pixel frame, then
// rate-encodes it into a back-pressurable (step, idx) spike stream.
module input_spike_scheduler #(
  parameter int N_INPUTS  = 16,
  parameter int DATA_W    = 8,
  parameter int NUM_STEPS = 8,
  parameter int IDX_W     = $clog2(N_INPUTS),
  parameter int STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_threshold,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  input  logic [DATA_W-1:0] i_s_data,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic [IDX_W-1:0]  o_m_idx,
  output logic [STEP_W-1:0] o_m_step,
  output logic              o_m_spike,
  output logic              o_m_last,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_INPUTS - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_STEPS - 1);

  logic [1:0]        state;
  logic [IDX_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [STEP_W-1:0] step;
  logic [DATA_W-1:0] pix [N_INPUTS];
  logic [DATA_W-1:0] acc [N_INPUTS];
  logic [DATA_W:0]   sum;
  logic              in_idle;
  logic              in_load;
  logic              in_run;
  logic              in_done;
  logic              last_beat;

  assign in_idle = (state == S_IDLE);
  assign in_load = (state == S_LOAD);
  assign in_run  = (state == S_RUN);
  assign in_done = (state == S_DONE);

  // Carry out of the accumulator is the spike; the residue stays in acc.
  assign sum       = {1'b0, acc[idx]} + {1'b0, pix[idx]};
  assign last_beat = (step == STEP_LAST) && (idx == IDX_LAST);

  assign o_s_ready = in_load;
  assign o_m_valid = in_run;
  assign o_m_idx   = idx;
  assign o_m_step  = step;
  assign o_m_spike = in_run & sum[DATA_W];
  assign o_m_last  = in_run & last_beat;
  assign o_busy    = in_load | in_run;
  assign o_done    = in_done;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      step  <= '0;
      for (int i = 0; i < N_INPUTS; i++) begin
        pix[i] <= '0;
        acc[i] <= '0;
      end
    end else begin
      unique case (1'b1)
        in_idle: begin
          if (i_start) begin
            state <= S_LOAD;
            cnt   <= '0;
            for (int i = 0; i < N_INPUTS; i++) begin
              acc[i] <= '0;
            end
          end
        end
        in_load: begin
          if (i_s_valid) begin
            pix[cnt] <= (i_s_data < i_threshold) ? '0 : i_s_data;
            if (cnt == IDX_LAST) begin
              state <= S_RUN;
              cnt   <= '0;
              idx   <= '0;
              step  <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        in_run: begin
          if (i_m_ready) begin
            acc[idx] <= sum[DATA_W-1:0];
            if (idx == IDX_LAST) begin
              idx  <= '0;
              step <= (step == STEP_LAST) ? '0 : step + 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
            if (last_beat) begin
              state <= S_DONE;
            end
          end
        end
        in_done: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
